// File: rtl/eem16_proj1_sweep.sv
// Stimulus sequencer and truth-table capture for the 3-input eem16_proj1 block.
// Walks x2..x0 through codes 0..7, samples z once per code, then publishes the result.
module eem16_proj1_sweep #(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       z,
    output logic       x2,
    output logic       x1,
    output logic       x0,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       tt_valid
);

    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE);

    generate
        if (DWELL < 2 || SETTLE < 1 || SETTLE >= DWELL) begin : g_param_check
            $error("eem16_proj1_sweep: illegal DWELL/SETTLE combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        FLUSH,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      code, code_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [7:0]      shadow, shadow_nx;
    logic [7:0]      tt_nx;
    logic            busy_nx, done_nx, tt_valid_nx;

    // The code register drives the stimulus pins directly, so they stay glitch-free.
    assign {x2, x1, x0} = code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            code     <= 3'd0;
            cnt      <= '0;
            shadow   <= 8'h00;
            tt       <= 8'h00;
            tt_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            code     <= code_nx;
            cnt      <= cnt_nx;
            shadow   <= shadow_nx;
            tt       <= tt_nx;
            tt_valid <= tt_valid_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        code_nx     = code;
        cnt_nx      = cnt;
        shadow_nx   = shadow;
        tt_nx       = tt;
        tt_valid_nx = tt_valid;
        busy_nx     = busy;
        done_nx     = 1'b0;

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                code_nx = 3'd0;
                if (start) begin
                    state_nx    = DRIVE;
                    cnt_nx      = '0;
                    busy_nx     = 1'b1;
                    tt_valid_nx = 1'b0;
                    shadow_nx   = 8'h00;
                end
            end

            DRIVE: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_SETTLE) begin
                    shadow_nx[code] = z;
                end
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (code == 3'd7) begin
                        state_nx = FLUSH;
                        code_nx  = 3'd0;
                    end else begin
                        code_nx = code + 3'd1;
                    end
                end
            end

            // Park the inputs at 000 so the downstream block ends in a known state.
            FLUSH: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = DONE;
                    busy_nx  = 1'b0;
                end
            end

            DONE: begin
                state_nx    = IDLE;
                done_nx     = 1'b1;
                tt_nx       = shadow;
                tt_valid_nx = 1'b1;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
